mdio_arbiter: RTL and testbench
===============================

MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 65535: the watchdog limit, in sys_clk cycles, for one engine transaction (legal range 2..65535).
REQ-002 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 4 bits: per-requester request level.
REQ-005 SHALL have port req_r_w, input, 4 bits: per-requester direction (1 = read, 0 = write).
REQ-006 SHALL have port req_phy_add, input, 20 bits: requester i uses bits [5i+4:5i].
REQ-007 SHALL have port req_reg_add, input, 20 bits: requester i uses bits [5i+4:5i].
REQ-008 SHALL have port req_wdata, input, 64 bits: requester i uses bits [16i+15:16i].
REQ-009 SHALL have port ack, output, 4 bits: one-cycle pulse; the request has been accepted and its fields captured.
REQ-010 SHALL have port done, output, 4 bits: one-cycle pulse; the transaction has completed.
REQ-011 SHALL have port rdata, output, 16 bits: read result, valid while done is high.
REQ-012 SHALL have port err, output, 1 bit: timeout flag, valid while done is high.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port grant_id, output, 2 bits: index of the current or last granted requester.
REQ-015 SHALL have port mdio_start_flag, output, 1 bit: one-cycle start pulse to the MDIO engine.
REQ-016 SHALL have ports mdio_r_w (1 bit), mdio_phy_add (5 bits), mdio_reg_add (5 bits) and mdio_write_reg_data (16 bits), all outputs, carrying the captured command fields.
REQ-017 SHALL have port mdio_read_reg_data, input, 16 bits, and port mdio_end_flag, input, 1 bit: the engine's read result and its completion pulse.

Function
REQ-018 SHALL implement a state machine with states IDLE, LAUNCH and BUSY.
REQ-019 In IDLE with req != 0 at a clock edge, the block SHALL:
- select requester i by round-robin, searching upward from (last_grant+1) mod 4;
- capture that requester's r_w, phy_add, reg_add and wdata onto the mdio_* outputs;
- set grant_id = i;
- enter LAUNCH.
REQ-020 During LAUNCH (exactly one cycle), ack[i] and mdio_start_flag SHALL both be 1. Accept latency is 1 cycle from the sampling edge.
REQ-021 LAUNCH SHALL always go to BUSY on the next edge, with ack and mdio_start_flag returning to 0.
REQ-022 A requester SHALL drop req on the edge at which it sees ack. If req is still high in the next IDLE, it is treated as a new request.
REQ-023 In BUSY with mdio_end_flag=1, the block SHALL:
- register rdata = mdio_read_reg_data (forced to 0 for writes), err = 0, done[i] = 1 for one cycle;
- set last_grant = i;
- go to IDLE.
REQ-024 In BUSY, the watchdog counter SHALL increment from 0 on every cycle without mdio_end_flag.
REQ-025 When the watchdog reaches TIMEOUT_CYC-1, the block SHALL:
- set done[i] = 1, err = 1, rdata = 16'hFFFF;
- set last_grant = i;
- go to IDLE.
REQ-026 If mdio_end_flag and watchdog expiry coincide, mdio_end_flag SHALL win (err = 0).
REQ-027 mdio_end_flag seen in IDLE or LAUNCH SHALL be ignored, with no done and no state change.
REQ-028 Request inputs, including req, SHALL be ignored outside IDLE; the mdio_* command outputs SHALL hold stable from LAUNCH until the return to IDLE.
REQ-029 The minimum spacing between consecutive accepts SHALL be one IDLE cycle after a done.
REQ-030 Only one bit of ack and one bit of done SHALL ever be high in a cycle, and ack and done SHALL never be high in the same cycle.
REQ-031 rdata and err SHALL hold their last values until the next done.

Reset
REQ-032 sys_rst_n low SHALL immediately, asynchronously, set:
- state = IDLE, last_grant = 3, watchdog = 0;
- ack = 0, done = 0, rdata = 0, err = 0, busy = 0, grant_id = 0;
- mdio_start_flag = 0, mdio_r_w = 1, mdio_phy_add = 0, mdio_reg_add = 0, mdio_write_reg_data = 0.
REQ-033 A reset asserted mid-transaction (LAUNCH or BUSY) SHALL abandon that transaction without issuing done. After release, the first grant SHALL go to the lowest-index requester.
REQ-034 After reset release, the first accept SHALL occur no earlier than the first rising edge at which sys_rst_n is sampled high.

Verification
REQ-035 A bench SHALL cover single write:
- stimulus: req=4'b0001, r_w=0, phy=0, reg=0, wdata=16'h0100; engine model returns end_flag 40 cycles after start;
- required response: ack[0] one cycle after the sampling edge, together with mdio_start_flag; done[0] one cycle after end_flag; err=0, rdata=0.
REQ-036 A bench SHALL cover single read:
- stimulus: requester 2 reads reg 1; engine returns 16'h796D;
- required response: done[2]=1, rdata=16'h796D, err=0, grant_id=2.
REQ-037 A bench SHALL cover round-robin fairness:
- stimulus: req=4'b1111, held and re-raised after each done;
- required response: grant order 0,1,2,3,0; exactly one ack bit per accept.
REQ-038 A bench SHALL cover timeout:
- stimulus: TIMEOUT_CYC=16, engine never asserts end_flag;
- required response: done pulse 16 cycles into BUSY, err=1, rdata=16'hFFFF; the next request is served normally.
REQ-039 A bench SHALL cover the end_flag/expiry collision:
- stimulus: end_flag asserted on the expiry cycle;
- required response: err=0, rdata equals mdio_read_reg_data.
REQ-040 A bench SHALL cover reset mid-BUSY:
- stimulus: assert sys_rst_n=0 during BUSY;
- required response: all outputs immediately at reset values; no done; after release with req=4'b1000, ack[3] is issued.

Source files
------------

// File: rtl/mdio_arbiter.sv
// Purpose: round-robin arbiter granting four requesters access to a single MDIO engine, with a per-transaction watchdog.
// Latency: ack/mdio_start_flag 1 cycle after the accepting edge; done/rdata/err 1 cycle after mdio_end_flag or watchdog expiry.
// Backpressure: one transaction in flight; requests are ignored outside IDLE, and the next accept can happen in the cycle that carries done.
module mdio_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  req_r_w,
  input  logic [19:0] req_phy_add,
  input  logic [19:0] req_reg_add,
  input  logic [63:0] req_wdata,
  output logic [3:0]  ack,
  output logic [3:0]  done,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        mdio_start_flag,
  output logic        mdio_r_w,
  output logic [4:0]  mdio_phy_add,
  output logic [4:0]  mdio_reg_add,
  output logic [15:0] mdio_write_reg_data,
  input  logic [15:0] mdio_read_reg_data,
  input  logic        mdio_end_flag
);

  // Watchdog value at which the BUSY cycle being sampled is the last one allowed
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  last_grant;
  logic [15:0] wdog;

  logic [1:0]  pick;
  logic        pick_vld;
  logic [1:0]  cand;
  logic [4:0]  pick_phy;
  logic [4:0]  pick_reg;
  logic [15:0] pick_wdata;

  // Round-robin search starting one above the last served requester; the
  // 4th candidate wraps back to last_grant itself
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    cand     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Field slices of the selected requester
  always_comb begin
    pick_phy   = req_phy_add[pick*5 +: 5];
    pick_reg   = req_reg_add[pick*5 +: 5];
    pick_wdata = req_wdata[pick*16 +: 16];
  end

  // Control FSM; every output is registered here
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state               <= IDLE;
      last_grant          <= 2'd3;
      wdog                <= 16'd0;
      ack                 <= 4'b0000;
      done                <= 4'b0000;
      rdata               <= 16'h0000;
      err                 <= 1'b0;
      busy                <= 1'b0;
      grant_id            <= 2'd0;
      mdio_start_flag     <= 1'b0;
      mdio_r_w            <= 1'b1;
      mdio_phy_add        <= 5'd0;
      mdio_reg_add        <= 5'd0;
      mdio_write_reg_data <= 16'h0000;
    end else begin
      ack             <= 4'b0000;
      done            <= 4'b0000;
      mdio_start_flag <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_id            <= pick;
            mdio_r_w            <= req_r_w[pick];
            mdio_phy_add        <= pick_phy;
            mdio_reg_add        <= pick_reg;
            mdio_write_reg_data <= pick_wdata;
            ack                 <= 4'b0001 << pick;
            mdio_start_flag     <= 1'b1;
            busy                <= 1'b1;
            state               <= LAUNCH;
          end
        end
        LAUNCH: begin
          wdog  <= 16'd0;
          state <= BUSY;
        end
        BUSY: begin
          // Completion is checked first so it wins over a simultaneous expiry
          if (mdio_end_flag) begin
            rdata      <= mdio_r_w ? mdio_read_reg_data : 16'h0000;
            err        <= 1'b0;
            done       <= 4'b0001 << grant_id;
            last_grant <= grant_id;
            wdog       <= 16'd0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (wdog == WD_LAST) begin
            rdata      <= 16'hFFFF;
            err        <= 1'b1;
            done       <= 4'b0001 << grant_id;
            last_grant <= grant_id;
            wdog       <= 16'd0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Purpose: self-checking bench for mdio_arbiter; two instances (default watchdog and a 16-cycle watchdog).
// Latency: the model predicts grant, accept cycle, BUSY length, done, rdata and err per transaction.
// Backpressure: the engine model answers after a chosen number of BUSY cycles, or never.
`timescale 1ns/1ps
module tb_mdio_arbiter;

  localparam int TO_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [3:0]  req_a = '0, req_b = '0;
  logic [3:0]  r_w = '0;
  logic [19:0] phy = '0, rg = '0;
  logic [63:0] wd = '0;
  logic [15:0] eng_rd = '0;
  logic        end_a = 1'b0, end_b = 1'b0;

  logic [3:0]  ack_a, done_a, ack_b, done_b;
  logic [15:0] rdata_a, rdata_b, mwd_a, mwd_b;
  logic        err_a, busy_a, start_a, mrw_a, err_b, busy_b, start_b, mrw_b;
  logic [1:0]  gid_a, gid_b;
  logic [4:0]  mphy_a, mreg_a, mphy_b, mreg_b;

  mdio_arbiter u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .req(req_a), .req_r_w(r_w),
    .req_phy_add(phy), .req_reg_add(rg), .req_wdata(wd),
    .ack(ack_a), .done(done_a), .rdata(rdata_a), .err(err_a), .busy(busy_a),
    .grant_id(gid_a), .mdio_start_flag(start_a), .mdio_r_w(mrw_a),
    .mdio_phy_add(mphy_a), .mdio_reg_add(mreg_a), .mdio_write_reg_data(mwd_a),
    .mdio_read_reg_data(eng_rd), .mdio_end_flag(end_a)
  );

  mdio_arbiter #(.TIMEOUT_CYC(TO_B)) u_dut_to (
    .sys_clk(clk), .sys_rst_n(rst_n), .req(req_b), .req_r_w(r_w),
    .req_phy_add(phy), .req_reg_add(rg), .req_wdata(wd),
    .ack(ack_b), .done(done_b), .rdata(rdata_b), .err(err_b), .busy(busy_b),
    .grant_id(gid_b), .mdio_start_flag(start_b), .mdio_r_w(mrw_b),
    .mdio_phy_add(mphy_b), .mdio_reg_add(mreg_b), .mdio_write_reg_data(mwd_b),
    .mdio_read_reg_data(eng_rd), .mdio_end_flag(end_b)
  );

  // Observation mux onto whichever instance the current transaction uses
  bit          sel_b = 1'b0;
  logic [3:0]  o_ack, o_done;
  logic [15:0] o_rdata;
  logic        o_err, o_busy, o_start;
  logic [1:0]  o_gid;
  logic [26:0] o_cmd;
  always_comb begin
    o_ack   = sel_b ? ack_b   : ack_a;
    o_done  = sel_b ? done_b  : done_a;
    o_rdata = sel_b ? rdata_b : rdata_a;
    o_err   = sel_b ? err_b   : err_a;
    o_busy  = sel_b ? busy_b  : busy_a;
    o_start = sel_b ? start_b : start_a;
    o_gid   = sel_b ? gid_b   : gid_a;
    o_cmd   = sel_b ? {mrw_b, mphy_b, mreg_b, mwd_b} : {mrw_a, mphy_a, mreg_a, mwd_a};
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: last served requester and last reported result per instance
  int          last_m[2];
  logic [15:0] prev_rdata[2];
  logic        prev_err[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return 0;
  endfunction

  task automatic scramble();
    r_w = 4'($urandom);
    phy = 20'($urandom);
    rg  = 20'($urandom);
    wd  = {$urandom, $urandom};
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ack",   32'({ack_a, ack_b}), 32'd0);
    chk("rst_done",  32'({done_a, done_b}), 32'd0);
    chk("rst_rdata", 32'({rdata_a, rdata_b}), 32'd0);
    chk("rst_flags", 32'({err_a, err_b, busy_a, busy_b, start_a, start_b}), 32'd0);
    chk("rst_gid",   32'({gid_a, gid_b}), 32'd0);
    chk("rst_cmd_a", 32'({mrw_a, mphy_a, mreg_a, mwd_a}), 32'h0400_0000);
    chk("rst_cmd_b", 32'({mrw_b, mphy_b, mreg_b, mwd_b}), 32'h0400_0000);
    req_a = '0; req_b = '0; end_a = 1'b0; end_b = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      last_m[i] = 3;
      prev_rdata[i] = 16'h0000;
      prev_err[i] = 1'b0;
    end
    // A stray completion pulse in IDLE must be ignored
    end_a = 1'b1; end_b = 1'b1;
    tick();
    end_a = 1'b0; end_b = 1'b0;
    chk("idle_end_ignored", 32'({done_a, done_b, busy_a, busy_b}), 32'd0);
  endtask

  // One full transaction on instance s; the engine ends it in BUSY cycle lat
  task automatic run_txn(input bit s, input logic [3:0] reqv, input int lat,
                         input logic [15:0] rd, output int got_g);
    int g, to, exp_cyc, busy_n, limit;
    logic xerr;
    logic [26:0] xcmd;
    logic [15:0] xrd;
    bit seen;
    to = s ? TO_B : 65535;
    g = rr_pick(last_m[s], reqv);
    xcmd = {r_w[g], phy[5*g +: 5], rg[5*g +: 5], wd[16*g +: 16]};
    xerr = (lat > to);
    exp_cyc = xerr ? to : lat;
    xrd = xerr ? 16'hFFFF : (r_w[g] ? rd : 16'h0000);
    sel_b = s;
    if (s) req_b = reqv; else req_a = reqv;
    tick();
    got_g = int'(o_gid);
    chk("ack", 32'(o_ack), 32'(1) << g);
    chk("start", 32'(o_start), 32'd1);
    chk("grant_id", 32'(o_gid), 32'(g));
    chk("cmd_capture", 32'(o_cmd), 32'(xcmd));
    chk("launch_busy_nodone", 32'({o_busy, o_done}), 32'h10);
    chk("result_hold", 32'({o_err, o_rdata}), 32'({prev_err[s], prev_rdata[s]}));
    req_a = '0; req_b = '0;
    scramble();
    busy_n = 0;
    seen = 1'b0;
    limit = exp_cyc + 4;
    for (int c = 0; c < limit && !seen; c++) begin
      tick();
      end_a = 1'b0; end_b = 1'b0;
      eng_rd = 16'($urandom);
      if (o_done != 4'b0000) begin
        seen = 1'b1;
      end else begin
        busy_n++;
        if (busy_n == 1) chk("busy_enter", 32'({o_busy, o_ack, o_start}), 32'h20);
        chk("cmd_hold", 32'(o_cmd), 32'(xcmd));
        scramble();
        if (busy_n == lat) begin
          if (s) end_b = 1'b1; else end_a = 1'b1;
          eng_rd = rd;
        end
      end
    end
    if (!seen) begin
      chk("done_seen", 32'd0, 32'd1);
    end else begin
      chk("busy_cycles", 32'(busy_n), 32'(exp_cyc));
      chk("done", 32'(o_done), 32'(1) << g);
      chk("rdata", 32'(o_rdata), 32'(xrd));
      chk("err", 32'(o_err), 32'(xerr));
      chk("done_idle", 32'({o_busy, o_ack, o_start}), 32'd0);
      last_m[s] = g;
      prev_rdata[s] = xrd;
      prev_err[s] = xerr;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int gg;
    int rr_order[5];
    rr_order = '{0, 1, 2, 3, 0};
    #2;
    apply_reset();

    // Single write from requester 0; engine answers 40 cycles after start
    scramble();
    r_w[0] = 1'b0; phy[4:0] = 5'd0; rg[4:0] = 5'd0; wd[15:0] = 16'h0100;
    run_txn(1'b0, 4'b0001, 40, 16'h1234, gg);
    chk("write_grant", 32'(gg), 32'd0);

    // Single read by requester 2 of register 1
    scramble();
    r_w[2] = 1'b1; rg[14:10] = 5'd1;
    run_txn(1'b0, 4'b0100, 7, 16'h796D, gg);
    chk("read_grant", 32'(gg), 32'd2);
    chk("read_rdata", 32'(rdata_a), 32'h796D);

    // Timeout: engine never answers; then a late end_flag in IDLE is ignored
    scramble();
    run_txn(1'b1, 4'b0001, 1000, 16'h0000, gg);
    end_b = 1'b1;
    tick();
    end_b = 1'b0;
    chk("late_end_ignored", 32'({done_b, busy_b}), 32'd0);
    scramble();
    run_txn(1'b1, 4'b0010, 5, 16'h5A5A, gg);

    // end_flag on the expiry cycle: completion wins
    scramble();
    r_w[2] = 1'b1;
    run_txn(1'b1, 4'b0100, TO_B, 16'hA5C3, gg);
    chk("collision_err", 32'(err_b), 32'd0);

    // Reset in the middle of BUSY, then requester 3 alone is served
    sel_b = 1'b0;
    scramble();
    req_a = 4'b0001;
    tick();
    req_a = 4'b0000;
    tick();
    tick();
    tick();
    chk("pre_reset_busy", 32'(busy_a), 32'd1);
    apply_reset();
    scramble();
    run_txn(1'b0, 4'b1000, 3, 16'hBEEF, gg);
    chk("post_reset_req3", 32'(gg), 32'd3);

    // Round-robin fairness with all requesters held after a fresh reset
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      scramble();
      run_txn(1'b0, 4'b1111, int'($urandom_range(1, 6)), 16'($urandom), gg);
      chk("rr_order", 32'(gg), 32'(rr_order[k]));
    end

    // Randomized traffic on both instances
    for (int n = 0; n < 40; n++) begin
      bit s;
      int lat;
      s = 1'($urandom_range(0, 1));
      lat = s ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 30));
      scramble();
      run_txn(s, 4'($urandom_range(1, 15)), lat, 16'($urandom), gg);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
